ks_audio_out: RTL and testbench
===============================

KS_AUDIO_OUT -- requirements
Module: ks_audio_out

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, sample width in bits.
REQ-002 The block SHALL have parameter DIV_WIDTH, default 16, width of the sigma-delta frame divider.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset: port clk_i (input, 1, clock) and port rst_i (input, 1, synchronous active-high reset).
REQ-004 Port en_i (input, 1) SHALL enable output modulation.
REQ-005 Port mode_i (input, 1) SHALL select the modulator: 0 = PWM, 1 = first-order sigma-delta.
REQ-006 Port div_i (input, DIV_WIDTH) SHALL set the sigma-delta frame period, in clocks, minus one.
REQ-007 Port volume_i (input, 3) SHALL set an arithmetic right-shift attenuation from 0 to 7.
REQ-008 Port sample_i (input, DATA_WIDTH) SHALL carry a signed two's-complement sample, for example the string output.
REQ-009 Port sample_valid_i (input, 1) SHALL indicate that sample_i is valid.
REQ-010 Port sample_ready_o (output, 1) SHALL indicate that the shadow buffer is empty.
REQ-011 Port frame_o (output, 1) SHALL pulse for one cycle at each frame boundary; it is the sample-request tick to the source.
REQ-012 Port underrun_o (output, 1) SHALL be a sticky underrun flag.
REQ-013 Port underrun_clr_i (input, 1) SHALL clear underrun_o.
REQ-014 Port audio_o (output, 1) SHALL be the registered 1-bit modulated audio output.

Function
REQ-015 A transfer SHALL occur on a cycle with sample_valid_i=1 and sample_ready_o=1; sample_i is then captured into the shadow register and shadow_full is set.
REQ-016 sample_ready_o SHALL equal NOT shadow_full, and SHALL be 0 while rst_i=1.
REQ-017 The level SHALL be computed when a sample enters the active register, in this order: shift sample >>> volume_i (sign-preserving), then invert the MSB to give unsigned offset binary L in 0..255.
REQ-018 At a frame boundary with shadow_full=1, the shadow contents SHALL move to the active register and shadow_full SHALL clear.
REQ-019 At a frame boundary with shadow_full=0 and no simultaneous transfer, the active level SHALL be held and underrun_o SHALL be set.
REQ-020 If a transfer coincides with a frame boundary while the shadow is empty, the sample SHALL load directly into the active register and no underrun SHALL be flagged.
REQ-021 mode_i SHALL be sampled only at frame boundaries; a change mid-frame SHALL take effect at the next boundary.
REQ-022 In PWM mode, an 8-bit counter c SHALL run 0..255 and wrap, the boundary SHALL be the wrap from 255 to 0, and audio_o SHALL register (c < L), giving duty L/256.
REQ-023 In sigma-delta mode, a 9-bit sum SHALL be formed each clock as acc + L; audio_o SHALL register the carry and acc SHALL take the low 8 bits.
REQ-024 In sigma-delta mode, a divider SHALL count 0..div_i, with the boundary when it equals div_i; div_i=0 SHALL give a boundary every clock.
REQ-025 frame_o SHALL assert in the cycle after each boundary.
REQ-026 While en_i=0: counters and acc SHALL hold at 0, audio_o SHALL be 0, frame_o SHALL be 0, no underrun SHALL be flagged, and the handshake SHALL remain operational.
REQ-027 If underrun_clr_i and an underrun event occur in the same cycle, set SHALL win.
REQ-028 Latency from a transfer into an empty pipeline to the first audio_o bit reflecting the new level SHALL be at most one frame plus 2 cycles.

Reset
REQ-029 While rst_i=1, the shadow and active registers SHALL be 0x00 (active level therefore 0x80, midscale).
REQ-030 While rst_i=1, c, acc and the divider SHALL be 0, and the registered mode SHALL be PWM.
REQ-031 While rst_i=1, audio_o, frame_o, underrun_o, sample_ready_o and shadow_full SHALL all be 0.
REQ-032 Reset asserted mid-frame SHALL abort the frame with no boundary pulse; the first boundary after release SHALL occur 256 clocks later in PWM mode.

Structure
REQ-033 Shared package ks_pkg SHALL hold DATA_WIDTH, PWM_FRAME=256 and the mode encoding constants.
REQ-034 The sigma-delta accumulator SHALL be a sub-module named ks_sigma_delta (inputs: level, enable; output: bit); the PWM logic SHALL stay inline.

Verification
REQ-035 Scenario 1: PWM mode, volume 0, push sample 0x40 -> L=0xC0; over the next full frame audio_o is high for 192 of 256 clocks.
REQ-036 Scenario 2: push 0x80 with volume 7 -> shift gives 0xFF, L=0x7F; audio_o is high for 127 of 256 clocks.
REQ-037 Scenario 3: sigma-delta mode, div_i=15, L=0x40 -> every 4-clock window contains exactly one high bit; frame_o pulses every 16 clocks.
REQ-038 Scenario 4: push one sample then stop -> the next boundary loads it; the following boundary sets underrun_o and holds the level; underrun_clr_i clears the flag.
REQ-039 Scenario 5: sample_valid_i held high continuously -> exactly one transfer per frame; sample_ready_o is low from the transfer until the next boundary.
REQ-040 Scenario 6: assert rst_i at c=100 -> all outputs are 0 next cycle; after release the active level is 0x80 and frame_o first pulses after 256 clocks.

Source files
------------

// File: rtl/ks_pkg.sv
// Shared constants for the ks audio output path: sample width, PWM frame
// length and modulator selection encoding.
package ks_pkg;
   localparam int DATA_WIDTH = 8;
   localparam int PWM_FRAME  = 256;
   localparam int CNT_WIDTH  = $clog2(PWM_FRAME);

   typedef enum logic {
      MODE_PWM = 1'b0,
      MODE_SD  = 1'b1
   } ks_mode_e;
endpackage

// File: rtl/ks_sigma_delta.sv
// First-order sigma-delta accumulator; bit_o is the carry of acc + level and
// is registered by the caller.
module ks_sigma_delta
   import ks_pkg::*;
#(
   parameter int LW = CNT_WIDTH
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic [LW-1:0] level_i,
   input  logic          en_i,
   output logic          bit_o
);
   logic [LW-1:0] acc_q;
   logic [LW:0]   sum;

   assign sum   = {1'b0, acc_q} + {1'b0, level_i};
   assign bit_o = en_i & sum[LW];

   // Accumulator parks at zero whenever this modulator is not selected.
   always_ff @(posedge clk_i) begin
      if (rst_i || !en_i) acc_q <= '0;
      else                acc_q <= sum[LW-1:0];
   end
endmodule

// File: rtl/ks_audio_out.sv
// 1-bit audio output: shadow/active sample double buffer feeding either a
// PWM or a first-order sigma-delta modulator, switched at frame boundaries.
module ks_audio_out
   import ks_pkg::*;
#(
   parameter int DATA_WIDTH = ks_pkg::DATA_WIDTH,
   parameter int DIV_WIDTH  = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  en_i,
   input  logic                  mode_i,
   input  logic [DIV_WIDTH-1:0]  div_i,
   input  logic [2:0]            volume_i,
   input  logic [DATA_WIDTH-1:0] sample_i,
   input  logic                  sample_valid_i,
   output logic                  sample_ready_o,
   output logic                  frame_o,
   output logic                  underrun_o,
   input  logic                  underrun_clr_i,
   output logic                  audio_o
);
   logic [DATA_WIDTH-1:0] shadow_q, active_q, load_val, shifted, active_ob;
   logic                  shadow_full_q;
   ks_mode_e              mode_q;
   logic [CNT_WIDTH-1:0]  cnt_q, level;
   logic [DIV_WIDTH-1:0]  div_q;
   logic                  xfer, bnd, sd_en, sd_bit;

   assign sample_ready_o = ~shadow_full_q & ~rst_i;
   assign xfer           = sample_valid_i & sample_ready_o;
   assign bnd            = en_i & ((mode_q == MODE_PWM) ? (cnt_q == CNT_WIDTH'(PWM_FRAME - 1))
                                                        : (div_q == div_i));

   // Attenuation is applied once, as the sample enters the active register.
   assign load_val  = shadow_full_q ? shadow_q : sample_i;
   assign shifted   = $signed(load_val) >>> volume_i;
   assign active_ob = {~active_q[DATA_WIDTH-1], active_q[DATA_WIDTH-2:0]};
   assign level     = active_ob[DATA_WIDTH-1 -: CNT_WIDTH];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         shadow_q      <= '0;
         active_q      <= '0;
         shadow_full_q <= 1'b0;
         underrun_o    <= 1'b0;
      end else begin
         // A transfer landing on a boundary with an empty shadow bypasses it.
         if (bnd && (shadow_full_q || xfer)) begin
            active_q      <= shifted;
            shadow_full_q <= 1'b0;
         end else if (xfer) begin
            shadow_q      <= sample_i;
            shadow_full_q <= 1'b1;
         end
         if (bnd && !shadow_full_q && !xfer) underrun_o <= 1'b1;
         else if (underrun_clr_i)            underrun_o <= 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q   <= '0;
         div_q   <= '0;
         mode_q  <= MODE_PWM;
         audio_o <= 1'b0;
         frame_o <= 1'b0;
      end else if (!en_i) begin
         cnt_q   <= '0;
         div_q   <= '0;
         audio_o <= 1'b0;
         frame_o <= 1'b0;
      end else begin
         frame_o <= bnd;
         if (bnd) mode_q <= ks_mode_e'(mode_i);
         // The idle modulator's counter is held at zero so a mode switch starts clean.
         if (mode_q == MODE_PWM) begin
            cnt_q   <= cnt_q + 1'b1;
            div_q   <= '0;
            audio_o <= (cnt_q < level);
         end else begin
            cnt_q   <= '0;
            div_q   <= bnd ? '0 : div_q + 1'b1;
            audio_o <= sd_bit;
         end
      end
   end

   assign sd_en = en_i & (mode_q == MODE_SD);

   ks_sigma_delta #(.LW(CNT_WIDTH)) u_sd (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .level_i (level),
      .en_i    (sd_en),
      .bit_o   (sd_bit)
   );
endmodule

// File: tb/tb_ks_audio_out.sv
// Directed and randomized checks of ks_audio_out against an arithmetic model
// of level, duty cycle, frame timing and handshake behaviour.
module tb_ks_audio_out;
   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic        en_i = 1'b1;
   logic        mode_i = 1'b0;
   logic [15:0] div_i = 16'd255;
   logic [2:0]  volume_i = 3'd0;
   logic [7:0]  sample_i = 8'd0;
   logic        sample_valid_i = 1'b0;
   logic        underrun_clr_i = 1'b0;
   logic        sample_ready_o, frame_o, underrun_o, audio_o;

   int checks = 0;
   int errors = 0;

   ks_audio_out #(.DATA_WIDTH(8), .DIV_WIDTH(16)) dut (
      .clk_i          (clk),
      .rst_i          (rst_i),
      .en_i           (en_i),
      .mode_i         (mode_i),
      .div_i          (div_i),
      .volume_i       (volume_i),
      .sample_i       (sample_i),
      .sample_valid_i (sample_valid_i),
      .sample_ready_o (sample_ready_o),
      .frame_o        (frame_o),
      .underrun_o     (underrun_o),
      .underrun_clr_i (underrun_clr_i),
      .audio_o        (audio_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Offset-binary level: floor(signed_sample / 2^vol) + 128.
   function automatic int model_level(input logic [7:0] s, input int v);
      int x, d, q;
      x = int'(s);
      if (x >= 128) x = x - 256;
      d = 1 << v;
      q = x / d;
      if ((x % d) != 0 && x < 0) q = q - 1;
      return q + 128;
   endfunction

   task automatic wait_frame(input string tag, input int budget);
      int n = 0;
      bit seen = 0;
      while (!seen && n < budget) begin
         @(negedge clk);
         n++;
         if (frame_o) seen = 1;
      end
      if (!seen) check({tag, "_timeout"}, 0, 1);
   endtask

   task automatic count_highs(input int n, output int h);
      h = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (audio_o) h++;
      end
   endtask

   task automatic push(input logic [7:0] s, input logic [2:0] v);
      int n = 0;
      volume_i = v;
      sample_i = s;
      while (!sample_ready_o && n < 600) begin
         @(negedge clk);
         n++;
      end
      check("push_ready", int'(sample_ready_o), 1);
      sample_valid_i = 1'b1;
      @(posedge clk);
      #1 sample_valid_i = 1'b0;
   endtask

   // Entered at a negedge with rst_i already seen by at least one posedge.
   task automatic post_reset_checks(input string tag);
      int n = 0;
      int h;
      check({tag, "_rst_audio"}, int'(audio_o), 0);
      check({tag, "_rst_frame"}, int'(frame_o), 0);
      check({tag, "_rst_underrun"}, int'(underrun_o), 0);
      check({tag, "_rst_ready"}, int'(sample_ready_o), 0);
      rst_i = 1'b0;
      #1 check({tag, "_ready_after_rst"}, int'(sample_ready_o), 1);
      while (n < 600) begin
         @(negedge clk);
         n++;
         if (frame_o) break;
      end
      check({tag, "_first_frame_clocks"}, n, 256);
      check({tag, "_first_underrun"}, int'(underrun_o), 1);
      count_highs(256, h);
      check({tag, "_midscale_duty"}, h, 128);
      underrun_clr_i = 1'b1;
      @(negedge clk);
      underrun_clr_i = 1'b0;
      @(negedge clk);
      check({tag, "_underrun_cleared"}, int'(underrun_o), 0);
   endtask

   initial begin
      int h, n, rdy, afr, aun, aau;
      logic [7:0] s;
      int v;

      repeat (3) @(negedge clk);
      post_reset_checks("init");

      // PWM, volume 0, 0x40 -> 192/256; then underrun holds the level.
      push(8'h40, 3'd0);
      wait_frame("s1", 600);
      count_highs(256, h);
      check("s1_duty", h, 192);
      check("s4_underrun_set", int'(underrun_o), 1);
      count_highs(256, h);
      check("s4_held_duty", h, 192);
      underrun_clr_i = 1'b1;
      @(negedge clk);
      underrun_clr_i = 1'b0;
      @(negedge clk);
      check("s4_clr", int'(underrun_o), 0);

      // 0x80 at volume 7 -> -1 -> 127/256.
      push(8'h80, 3'd7);
      wait_frame("s2", 600);
      count_highs(256, h);
      check("s2_duty", h, 127);

      // Clear held across an underrun boundary: set must win.
      underrun_clr_i = 1'b1;
      wait_frame("setwin", 600);
      check("setwin_underrun", int'(underrun_o), 1);
      underrun_clr_i = 1'b0;

      for (int i = 0; i < 4; i++) begin
         s = 8'($urandom_range(0, 255));
         v = $urandom_range(0, 7);
         push(s, 3'(v));
         wait_frame("rnd_pwm", 600);
         count_highs(256, h);
         check($sformatf("rnd_pwm_duty_s%0h_v%0d", s, v), h, model_level(s, v));
      end

      // Valid held high: one transfer per frame.
      sample_i = 8'($urandom_range(0, 255));
      volume_i = 3'd0;
      sample_valid_i = 1'b1;
      wait_frame("s5", 600);
      rdy = 0;
      for (int i = 0; i < 256; i++) begin
         if (i > 0) @(negedge clk);
         if (sample_ready_o) rdy++;
      end
      check("s5_transfers_per_frame", rdy, 1);
      sample_valid_i = 1'b0;

      // Sigma-delta, div 15, L=0x40.
      mode_i = 1'b1;
      div_i = 16'd15;
      push(8'hC0, 3'd0);
      wait_frame("s3_switch", 600);
      wait_frame("s3_sync", 40);
      n = 0;
      while (n < 40) begin
         @(negedge clk);
         n++;
         if (frame_o) break;
      end
      check("s3_frame_period", n, 16);
      for (int w = 0; w < 8; w++) begin
         count_highs(4, h);
         check($sformatf("s3_window%0d", w), h, 1);
      end

      // Sigma-delta with 256-clock frames: a frame at constant L yields L highs.
      div_i = 16'd255;
      wait_frame("sd_sync", 600);
      for (int i = 0; i < 3; i++) begin
         s = 8'($urandom_range(0, 255));
         v = $urandom_range(0, 7);
         push(s, 3'(v));
         wait_frame("rnd_sd", 600);
         count_highs(256, h);
         check($sformatf("rnd_sd_density_s%0h_v%0d", s, v), h, model_level(s, v));
      end

      // Disabled: outputs quiet, handshake still accepts a sample.
      underrun_clr_i = 1'b1;
      @(negedge clk);
      underrun_clr_i = 1'b0;
      en_i = 1'b0;
      s = 8'($urandom_range(0, 255));
      push(s, 3'd0);
      @(negedge clk);
      check("en0_ready_after_xfer", int'(sample_ready_o), 0);
      afr = 0; aun = 0; aau = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         afr += int'(frame_o);
         aun += int'(underrun_o);
         aau += int'(audio_o);
      end
      check("en0_frame", afr, 0);
      check("en0_underrun", aun, 0);
      check("en0_audio", aau, 0);
      en_i = 1'b1;
      n = 0;
      while (n < 600) begin
         @(negedge clk);
         n++;
         if (frame_o) break;
      end
      check("en1_first_frame_clocks", n, 256);
      count_highs(256, h);
      check("en1_density", h, model_level(s, 0));

      // Back to PWM, reset at c=100.
      mode_i = 1'b0;
      wait_frame("s6_switch", 600);
      repeat (100) @(negedge clk);
      rst_i = 1'b1;
      #1 check("s6_ready_in_rst", int'(sample_ready_o), 0);
      @(negedge clk);
      post_reset_checks("s6");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
